// File: rtl/uartprobe_rx_if.sv
// Byte-stream handshake between the UART receiver and the probe command decoder.
interface uartprobe_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uartprobe_rx.sv
// 8N1 UART receiver with a one-entry output buffer and error pulses.
module uartprobe_rx #(
  parameter int unsigned BIT_CYCLES = 868
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           uart_rx,
  uartprobe_rx_if.master bus
);

  localparam int unsigned CW = $clog2(BIT_CYCLES);
  localparam int unsigned H  = BIT_CYCLES / 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  assign rx_s          = sync_q[1];
  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

  // State, synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame sequencing, bit sampling and output buffer update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && bus.rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CW'(H - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == CW'(BIT_CYCLES - 1)) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == CW'(BIT_CYCLES - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            // A simultaneous handshake frees the slot in the same cycle.
            if (!valid_q || bus.rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uartprobe_rx.sv
// Self-checking bench for uartprobe_rx with a frame-level reference model.
module tb_uartprobe_rx;

  localparam int BIT = 16;
  localparam int LAT = 2 + BIT / 2 + 9 * BIT + 1;

  typedef struct {
    int         c;
    logic [7:0] d;
    logic       ok;
  } ev_t;

  logic clk;
  logic reset;
  logic uart_rx;

  uartprobe_rx_if bus ();

  uartprobe_rx #(.BIT_CYCLES(BIT)) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         failures;
  int         cyc;
  bit         chk_en;
  int         ready_mode;
  int         pulse_cyc;
  ev_t        ev_q[$];
  logic       m_valid, m_ferr, m_ovr;
  logic [7:0] m_data;
  int         vrise_cyc, vhigh_cnt, ferr_cnt, ovr_cnt;
  logic       obs_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_obs();
    vrise_cyc = -1;
    vhigh_cnt = 0;
    ferr_cnt  = 0;
    ovr_cnt   = 0;
    obs_prev  = bus.rx_valid;
  endtask

  // One clock: advance the model on the edge, then compare and drive.
  task automatic tick();
    logic       rdy;
    logic       nv, nf, no;
    logic [7:0] nd;
    @(posedge clk);
    rdy = bus.rx_ready;
    cyc++;
    if (reset) begin
      nv = 1'b0; nf = 1'b0; no = 1'b0; nd = 8'h00;
      ev_q.delete();
    end else begin
      nv = m_valid; nd = m_data; nf = 1'b0; no = 1'b0;
      if (m_valid && rdy) nv = 1'b0;
      if (ev_q.size() > 0 && ev_q[0].c == cyc) begin
        if (ev_q[0].ok) begin
          if (!m_valid || rdy) begin
            nd = ev_q[0].d;
            nv = 1'b1;
          end else begin
            no = 1'b1;
          end
        end else begin
          nf = 1'b1;
        end
        void'(ev_q.pop_front());
      end
    end
    m_valid = nv; m_data = nd; m_ferr = nf; m_ovr = no;
    #1;
    if (chk_en) begin
      chk("cyc_valid", 32'(bus.rx_valid), 32'(m_valid));
      chk("cyc_data", 32'(bus.rx_data), 32'(m_data));
      chk("cyc_frame_err", 32'(bus.frame_err), 32'(m_ferr));
      chk("cyc_overrun", 32'(bus.overrun), 32'(m_ovr));
    end
    if (bus.rx_valid === 1'b1 && obs_prev !== 1'b1) vrise_cyc = cyc;
    if (bus.rx_valid === 1'b1) vhigh_cnt++;
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.overrun === 1'b1) ovr_cnt++;
    obs_prev = bus.rx_valid;
    if (ready_mode == 1) bus.rx_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2) bus.rx_ready = (cyc == pulse_cyc);
  endtask

  // Drives one 8N1 frame starting in the current cycle; abort_bit >= 0 resets mid-frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_bit,
                            input int stop_hold);
    ev_t e;
    e.c = cyc + LAT; e.d = b; e.ok = stop;
    ev_q.push_back(e);
    for (int k = 0; k < 10; k++) begin
      if (k == 0) uart_rx = 1'b0;
      else if (k == 9) uart_rx = stop;
      else uart_rx = b[k-1];
      if (abort_bit >= 0 && k == abort_bit + 1) begin
        repeat (BIT / 2) tick();
        reset = 1'b1;
        uart_rx = 1'b1;
        tick();
        reset = 1'b0;
        return;
      end
      repeat ((k == 9) ? BIT * stop_hold : BIT) tick();
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; cyc = 0; chk_en = 1'b0;
    ready_mode = 0; pulse_cyc = -1;
    m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
    reset = 1'b1; uart_rx = 1'b1; bus.rx_ready = 1'b0;
    clear_obs();
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    tick();
    chk("reset_valid", 32'(bus.rx_valid), 32'd0);
    chk("reset_data", 32'(bus.rx_data), 32'd0);
    chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
    chk("reset_overrun", 32'(bus.overrun), 32'd0);

    // Normal byte with the consumer always ready.
    bus.rx_ready = 1'b1;
    idle(5);
    clear_obs();
    n = cyc;
    send_frame(8'hA5, 1'b1, -1, 1);
    idle(4);
    chk("a5_rise_cycle", 32'(vrise_cyc), 32'(n + LAT));
    chk("a5_valid_cycles", 32'(vhigh_cnt), 32'd1);
    chk("a5_data", 32'(bus.rx_data), 32'hA5);

    // Short glitch, then a real byte.
    clear_obs();
    uart_rx = 1'b0;
    repeat (3) tick();
    idle(30);
    chk("glitch_valid", 32'(vhigh_cnt), 32'd0);
    chk("glitch_frame_err", 32'(ferr_cnt), 32'd0);
    n = cyc;
    send_frame(8'h3C, 1'b1, -1, 1);
    idle(4);
    chk("3c_rise_cycle", 32'(vrise_cyc), 32'(n + LAT));
    chk("3c_data", 32'(bus.rx_data), 32'h3C);

    // Break: stop bit low and line held low for 40 bit times.
    clear_obs();
    send_frame(8'hFF, 1'b0, -1, 40);
    idle(2 * BIT);
    chk("break_frame_err_count", 32'(ferr_cnt), 32'd1);
    chk("break_valid", 32'(vhigh_cnt), 32'd0);
    send_frame(8'h81, 1'b1, -1, 1);
    idle(4);
    chk("81_valid_cycles", 32'(vhigh_cnt), 32'd1);
    chk("81_data", 32'(bus.rx_data), 32'h81);

    // Overrun: two back-to-back bytes, nobody consuming.
    bus.rx_ready = 1'b0;
    clear_obs();
    send_frame(8'h11, 1'b1, -1, 1);
    send_frame(8'h22, 1'b1, -1, 1);
    idle(4);
    chk("ovr_data", 32'(bus.rx_data), 32'h11);
    chk("ovr_valid", 32'(bus.rx_valid), 32'd1);
    chk("ovr_count", 32'(ovr_cnt), 32'd1);
    bus.rx_ready = 1'b1;
    idle(2);
    chk("ovr_drain_valid", 32'(bus.rx_valid), 32'd0);

    // Consume in exactly the cycle the next byte completes.
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1, 1);
    clear_obs();
    ready_mode = 2;
    pulse_cyc = cyc + LAT - 1;
    send_frame(8'h22, 1'b1, -1, 1);
    idle(4);
    ready_mode = 0;
    bus.rx_ready = 1'b0;
    chk("simul_data", 32'(bus.rx_data), 32'h22);
    chk("simul_valid", 32'(bus.rx_valid), 32'd1);
    chk("simul_overrun", 32'(ovr_cnt), 32'd0);
    bus.rx_ready = 1'b1;
    idle(2);
    bus.rx_ready = 1'b0;

    // Reset during bit 4 with a byte still buffered.
    send_frame(8'h99, 1'b1, -1, 1);
    idle(2);
    send_frame(8'h5A, 1'b1, 4, 1);
    chk("rst_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_data", 32'(bus.rx_data), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    clear_obs();
    bus.rx_ready = 1'b1;
    idle(20);
    send_frame(8'hC3, 1'b1, -1, 1);
    idle(4);
    chk("c3_valid_cycles", 32'(vhigh_cnt), 32'd1);
    chk("c3_data", 32'(bus.rx_data), 32'hC3);

    // Random bytes, stop bits, gaps and consumer readiness.
    ready_mode = 1;
    for (int i = 0; i < 14; i++) begin
      logic [7:0] b;
      logic       s;
      int         g;
      b = 8'($urandom);
      s = ($urandom_range(0, 5) != 0);
      send_frame(b, s, -1, 1);
      g = s ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 12));
      idle(g);
    end
    ready_mode = 0;
    bus.rx_ready = 1'b1;
    idle(LAT + BIT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
